// File: rtl/cpu_bus_pkg.sv
// Shared types and default geometry for the CPU external-bus sequencer.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } bus_kind_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } bus_state_e;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/cpu_bus_interface_timer.sv
// Counts consecutive RDY-low cycles of one read; expired_o fires combinationally on the
// counting edge that would make the count reach TIMEOUT_CYCLES.
module bus_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_bus_interface.sv
// External-bus sequencer: one core request -> one bus cycle, registered pins and response.
// Optional read wait timeout enabled by defining CPU_BUS_WAIT_TIMEOUT_EN.
module cpu_bus_interface
    import cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_kind,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  RDY,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [DATA_WIDTH-1:0] OUTPUT_ENABLE,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    output logic                  RW,
    output logic                  SYNC
);

    bus_state_e            state_q, state_d;
    bus_kind_e             kind_q, kind_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic                  sync_q, sync_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] oe_q, oe_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic      in_read;
    logic      done;
    logic      accept;
    logic      timed_out;
    bus_kind_e req_kind_n;

    // Reserved encoding 3 is folded into READ so the rest of the FSM sees only three kinds.
    always_comb begin
        req_kind_n = READ;
        if (req_kind == 2'd0) req_kind_n = FETCH;
        if (req_kind == 2'd2) req_kind_n = WRITE;
    end

    assign in_read   = (state_q == BUS) && (kind_q != WRITE);
    assign done      = (state_q == BUS) && ((kind_q == WRITE) || RDY || timed_out);
    assign req_ready = (state_q == IDLE) || done;
    assign accept    = req_valid && req_ready;

`ifdef CPU_BUS_WAIT_TIMEOUT_EN
    logic wait_cnt_en;
    assign wait_cnt_en = in_read && !RDY;

    bus_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear_i  (done),
        .count_i  (wait_cnt_en),
        .expired_o(timed_out)
    );
`else
    assign timed_out = 1'b0;
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    end
`endif

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        sync_d      = sync_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = 1'b0;

        if (done && in_read) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = timed_out ? '0 : DATA_IN;
            rsp_err_d   = timed_out;
        end

        // A fresh accept owns the pins next cycle even when it coincides with a completion.
        if (accept) begin
            state_d = BUS;
            kind_d  = req_kind_n;
            addr_d  = req_addr;
            rw_d    = (req_kind_n != WRITE);
            sync_d  = (req_kind_n == FETCH);
            oe_d    = '0;
            if (req_kind_n == WRITE) begin
                dout_d = req_wdata;
                oe_d   = '1;
            end
        end else if (done) begin
            state_d = IDLE;
            rw_d    = 1'b1;
            sync_d  = 1'b0;
            oe_d    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            kind_q      <= READ;
            addr_q      <= '0;
            rw_q        <= 1'b1;
            sync_q      <= 1'b0;
            dout_q      <= '0;
            oe_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            sync_q      <= sync_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign ADDRESS       = addr_q;
    assign RW            = rw_q;
    assign SYNC          = sync_q;
    assign DATA_OUT      = dout_q;
    assign OUTPUT_ENABLE = oe_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_cpu_bus_interface.sv
// Directed bench for cpu_bus_interface with hand-computed expectations.
module tb_cpu_bus_interface;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        RDY;
    logic [7:0]  DATA_IN;
    logic [7:0]  DATA_OUT;
    logic [7:0]  OUTPUT_ENABLE;
    logic [15:0] ADDRESS;
    logic        RW;
    logic        SYNC;

    int errors = 0;
    int checks = 0;
    int seen_rsp;

    always #5 CLK = ~CLK;

    cpu_bus_interface #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (16),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .RDY          (RDY),
        .DATA_IN      (DATA_IN),
        .DATA_OUT     (DATA_OUT),
        .OUTPUT_ENABLE(OUTPUT_ENABLE),
        .ADDRESS      (ADDRESS),
        .RW           (RW),
        .SYNC         (SYNC)
    );

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] wd);
        req_valid = 1'b1;
        req_kind  = kind;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    initial begin
        RST_N = 1'b0; req_valid = 1'b0; req_kind = 2'd1; req_addr = '0; req_wdata = '0;
        RDY = 1'b1; DATA_IN = '0;
        tick(); tick();
        check("rst_address", 32'(ADDRESS), 32'h0000);
        check("rst_rw", 32'(RW), 32'h1);
        check("rst_sync", 32'(SYNC), 32'h0);
        check("rst_oe", 32'(OUTPUT_ENABLE), 32'h00);
        check("rst_dout", 32'(DATA_OUT), 32'h00);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        RST_N = 1'b1;
        tick();
        check("idle_ready", 32'(req_ready), 32'h1);

        // 1: fetch
        issue(2'd0, 16'hFFFC, 8'h00); RDY = 1'b1; DATA_IN = 8'hA9;
        tick();
        req_valid = 1'b0;
        check("f_addr", 32'(ADDRESS), 32'hFFFC);
        check("f_sync", 32'(SYNC), 32'h1);
        check("f_rw", 32'(RW), 32'h1);
        check("f_oe", 32'(OUTPUT_ENABLE), 32'h00);
        check("f_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        check("f_rsp_valid", 32'(rsp_valid), 32'h1);
        check("f_rsp_data", 32'(rsp_data), 32'hA9);
        check("f_sync_off", 32'(SYNC), 32'h0);
        tick();
        check("f_rsp_pulse", 32'(rsp_valid), 32'h0);

        // 2: write with RDY low
        issue(2'd2, 16'h0200, 8'h5A); RDY = 1'b0;
        tick();
        req_valid = 1'b0;
        check("w_rw", 32'(RW), 32'h0);
        check("w_oe", 32'(OUTPUT_ENABLE), 32'hFF);
        check("w_dout", 32'(DATA_OUT), 32'h5A);
        check("w_addr", 32'(ADDRESS), 32'h0200);
        #1 check("w_ready", 32'(req_ready), 32'h1);
        tick();
        check("w_rw_idle", 32'(RW), 32'h1);
        check("w_oe_idle", 32'(OUTPUT_ENABLE), 32'h00);
        check("w_dout_hold", 32'(DATA_OUT), 32'h5A);
        check("w_addr_hold", 32'(ADDRESS), 32'h0200);
        check("w_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        check("w_no_rsp2", 32'(rsp_valid), 32'h0);

        // 3: read with three wait states
        issue(2'd1, 16'h1234, 8'h00); RDY = 1'b0; DATA_IN = 8'h11;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("r_addr_wait", 32'(ADDRESS), 32'h1234);
            check("r_ready_wait", 32'(req_ready), 32'h0);
            check("r_rsp_wait", 32'(rsp_valid), 32'h0);
            tick();
        end
        RDY = 1'b1; DATA_IN = 8'h3C;
        #1;
        check("r_addr_last", 32'(ADDRESS), 32'h1234);
        check("r_ready_done", 32'(req_ready), 32'h1);
        tick();
        check("r_rsp_valid", 32'(rsp_valid), 32'h1);
        check("r_rsp_data", 32'(rsp_data), 32'h3C);
        check("r_rw_idle", 32'(RW), 32'h1);

        // 4: back-to-back fetch, read, write
        issue(2'd0, 16'h8000, 8'h00); RDY = 1'b1; DATA_IN = 8'h11;
        tick();
        check("b_addr0", 32'(ADDRESS), 32'h8000);
        check("b_sync0", 32'(SYNC), 32'h1);
        issue(2'd1, 16'h8001, 8'h00);
        #1 check("b_ready0", 32'(req_ready), 32'h1);
        tick();
        check("b_addr1", 32'(ADDRESS), 32'h8001);
        check("b_sync1", 32'(SYNC), 32'h0);
        check("b_rw1", 32'(RW), 32'h1);
        check("b_rsp1", 32'(rsp_valid), 32'h1);
        check("b_data1", 32'(rsp_data), 32'h11);
        issue(2'd2, 16'h8002, 8'h77); DATA_IN = 8'h22;
        tick();
        req_valid = 1'b0;
        check("b_addr2", 32'(ADDRESS), 32'h8002);
        check("b_sync2", 32'(SYNC), 32'h0);
        check("b_rw2", 32'(RW), 32'h0);
        check("b_oe2", 32'(OUTPUT_ENABLE), 32'hFF);
        check("b_dout2", 32'(DATA_OUT), 32'h77);
        check("b_rsp2", 32'(rsp_valid), 32'h1);
        check("b_data2", 32'(rsp_data), 32'h22);
        tick();
        check("b_rsp_end", 32'(rsp_valid), 32'h0);
        check("b_rw_end", 32'(RW), 32'h1);

        // 5: reset mid-read
        issue(2'd1, 16'h4000, 8'h00); RDY = 1'b0; DATA_IN = 8'h99;
        tick();
        req_valid = 1'b0;
        tick();
        check("x_in_bus", 32'(ADDRESS), 32'h4000);
        RST_N = 1'b0;
        tick();
        check("x_addr", 32'(ADDRESS), 32'h0000);
        check("x_rw", 32'(RW), 32'h1);
        check("x_sync", 32'(SYNC), 32'h0);
        check("x_dout", 32'(DATA_OUT), 32'h00);
        check("x_oe", 32'(OUTPUT_ENABLE), 32'h00);
        check("x_rsp_data", 32'(rsp_data), 32'h00);
        check("x_rsp_valid", 32'(rsp_valid), 32'h0);
        RST_N = 1'b1; RDY = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid === 1'b1) seen_rsp++;
        end
        check("x_no_rsp_after", 32'(seen_rsp), 32'h0);
        check("x_ready_idle", 32'(req_ready), 32'h1);

        // 6: read with RDY stuck low
        issue(2'd1, 16'h5000, 8'h00); RDY = 1'b0; DATA_IN = 8'hEE;
        tick();
        req_valid = 1'b0;
`ifdef CPU_BUS_WAIT_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check("t_rsp_wait", 32'(rsp_valid), 32'h0);
            tick();
        end
        check("t_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t_rsp_err", 32'(rsp_err), 32'h1);
        check("t_rsp_data", 32'(rsp_data), 32'h00);
        tick();
        check("t_rsp_pulse", 32'(rsp_valid), 32'h0);
        check("t_err_pulse", 32'(rsp_err), 32'h0);
`else
        seen_rsp = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid === 1'b1) seen_rsp++;
            tick();
        end
        check("t_no_rsp_100", 32'(seen_rsp), 32'h0);
        check("t_ready_low", 32'(req_ready), 32'h0);
        check("t_addr_held", 32'(ADDRESS), 32'h5000);
        RDY = 1'b1;
        tick();
        check("t_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t_rsp_data", 32'(rsp_data), 32'hEE);
        check("t_rsp_err", 32'(rsp_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
